// File: rtl/fdct8x8_serial_if.sv
// Stream bundle for the serial 8x8 forward DCT.
//   in_valid/in_ready/in_data    : sample stream into the block (row-major X[y][x])
//   out_valid/out_ready/out_data : coefficient stream out of the block (row-major F[v][u])
//   busy                         : block is not in its load phase
// master: the producer/consumer side (testbench); slave: the DCT block.
interface fdct8x8_serial_if #(
  parameter int unsigned DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/fdct8x8_serial.sv
// Serial 8x8 orthonormal forward DCT using one time-shared MAC.
// Loads 64 signed samples, runs a 512-cycle row pass (T = X * C^T, 32-bit exact)
// and a 512-cycle column pass (F = C * T, 48-bit accumulate, round and saturate),
// then streams the 64 coefficients out.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave view of fdct8x8_serial_if (sample in, coefficient out, busy)
module fdct8x8_serial #(
  parameter int unsigned DATA_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  fdct8x8_serial_if.slave  bus
);

  localparam logic [1:0] LOAD   = 2'd0;
  localparam logic [1:0] ROW    = 2'd1;
  localparam logic [1:0] COL    = 2'd2;
  localparam logic [1:0] UNLOAD = 2'd3;

  localparam logic signed [47:0] RoundHalf = 48'sd8388608;  // 2^23

  // C[u][x] = round(4096 * c(u) * cos((2x+1)u*pi/16)), folded onto one quarter wave.
  function automatic logic signed [12:0] cos_rom(input logic [2:0] u, input logic [2:0] x);
    logic [4:0]  k;
    logic [3:0]  m;
    logic        neg;
    logic [11:0] mag;
    k = {1'b0, x, 1'b1} * {2'b00, u};  // (2x+1)u mod 32
    if (k <= 5'd8) begin
      m = k[3:0];              neg = 1'b0;
    end else if (k <= 5'd16) begin
      m = 4'(5'd16 - k);       neg = 1'b1;
    end else if (k <= 5'd24) begin
      m = 4'(k - 5'd16);       neg = 1'b1;
    end else begin
      m = 4'(6'd32 - {1'b0, k}); neg = 1'b0;
    end
    case (m)
      4'd0:    mag = 12'd2048;
      4'd1:    mag = 12'd2009;
      4'd2:    mag = 12'd1892;
      4'd3:    mag = 12'd1703;
      4'd4:    mag = 12'd1448;
      4'd5:    mag = 12'd1138;
      4'd6:    mag = 12'd784;
      4'd7:    mag = 12'd400;
      default: mag = 12'd0;
    endcase
    if (u == 3'd0) return 13'sd1448;
    return neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  logic [1:0]         state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic [8:0]         cnt_q, cnt_d;
  logic signed [47:0] acc_q, acc_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;

  logic [DATA_W-1:0]  xbuf [64];
  logic signed [31:0] tbuf [64];
  logic [DATA_W-1:0]  obuf [64];

  // Loop counters: ROW uses {y,u,x}, COL uses {v,u,y}.
  logic [2:0] lp_hi, lp_mid, lp_lo;
  assign lp_hi  = cnt_q[8:6];
  assign lp_mid = cnt_q[5:3];
  assign lp_lo  = cnt_q[2:0];

  logic signed [31:0] op_a;
  logic signed [12:0] op_c;
  logic signed [44:0] a_ext, c_ext, prod;
  logic signed [47:0] acc_sum;
  logic signed [23:0] rq;
  logic [DATA_W-1:0]  sat;

  always_comb begin
    if (state_q == COL) begin
      op_a = tbuf[{lp_lo, lp_mid}];
      op_c = cos_rom(lp_hi, lp_lo);
    end else begin
      op_a = 32'($signed(xbuf[{lp_hi, lp_lo}]));
      op_c = cos_rom(lp_mid, lp_lo);
    end
    a_ext   = 45'(op_a);
    c_ext   = 45'(op_c);
    prod    = a_ext * c_ext;
    acc_sum = ((lp_lo == 3'd0) ? 48'sd0 : acc_q) + 48'(prod);
    rq      = 24'((acc_sum + RoundHalf) >>> 24);
    // Saturate when the rounded value does not fit in DATA_W signed bits.
    if (rq[23:DATA_W-1] == {(25 - DATA_W){rq[23]}}) begin
      sat = rq[DATA_W-1:0];
    end else if (rq[23]) begin
      sat = {1'b1, {(DATA_W - 1){1'b0}}};
    end else begin
      sat = {1'b0, {(DATA_W - 1){1'b1}}};
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd63) state_d = ROW;
        end
      end
      ROW: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == 9'd511) state_d = COL;
      end
      COL: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == 9'd511) begin
          state_d = UNLOAD;
          // F[0][0] was written long before the final column MAC.
          out_data_d = obuf[0];
        end
      end
      default: begin
        if (bus.out_ready) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd63) begin
            state_d    = LOAD;
            out_data_d = '0;
          end else begin
            out_data_d = obuf[idx_q + 6'd1];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      idx_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

  // Buffers carry no reset; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && bus.in_valid) xbuf[idx_q] <= bus.in_data;
    if (state_q == ROW && lp_lo == 3'd7) tbuf[{lp_hi, lp_mid}] <= acc_sum[31:0];
    if (state_q == COL && lp_lo == 3'd7) obuf[{lp_hi, lp_mid}] <= sat;
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.busy      = (state_q != LOAD);
  assign bus.out_valid = (state_q == UNLOAD);
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_fdct8x8_serial.sv
// Self-checking bench for fdct8x8_serial: directed and random blocks compared
// against a real-valued-ROM / integer-arithmetic DCT reference.
module tb_fdct8x8_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fdct8x8_serial_if #(.DATA_W(16)) bus ();

  fdct8x8_serial #(.DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cr   [8][8];
  int xin  [64];
  int fexp [64];
  int got  [64];

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  task automatic build_rom();
    real pi, cu;
    pi = 3.14159265358979;
    for (int u = 0; u < 8; u++) begin
      cu = (u == 0) ? $sqrt(1.0 / 8.0) : 0.5;
      for (int x = 0; x < 8; x++)
        cr[u][x] = rnd(4096.0 * cu * $cos(real'((2 * x + 1) * u) * pi / 16.0));
    end
  endtask

  // T = X * C^T exactly, then F = round-half-up(C * T / 2^24), clamped to 16 bits.
  task automatic model();
    longint t [64];
    longint acc, q;
    for (int y = 0; y < 8; y++)
      for (int u = 0; u < 8; u++) begin
        acc = 0;
        for (int x = 0; x < 8; x++) acc += longint'(xin[y * 8 + x]) * cr[u][x];
        t[y * 8 + u] = acc;
      end
    for (int v = 0; v < 8; v++)
      for (int u = 0; u < 8; u++) begin
        acc = 0;
        for (int y = 0; y < 8; y++) acc += t[y * 8 + u] * cr[v][y];
        q = (acc + (longint'(1) << 23)) >>> 24;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        fexp[v * 8 + u] = int'(q);
      end
  endtask

  task automatic fill(input int val);
    for (int i = 0; i < 64; i++) xin[i] = val;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) xin[i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  // Present the 64 samples; optionally insert idle gaps, or leave in_valid high afterwards.
  task automatic load_block(input bit gaps, input bit hold);
    for (int i = 0; i < 64; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(xin[i]);
      @(posedge clk); #1;
    end
    if (hold) bus.in_data = 16'h5a5a;
    else bus.in_valid = 1'b0;
  endtask

  // Wait for results, drain all 64 beats and compare against the reference.
  task automatic run_block(input bit rand_rdy, input string name);
    int lat, n, guard, bad_stable, bad_inrdy;
    bit stalled, rdy;
    logic [15:0] held;
    lat = 0;
    bus.out_ready = 1'b0;
    while (!bus.out_valid && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    check_eq({name, " latency"}, lat, 1024);
    n = 0; guard = 0; bad_stable = 0; bad_inrdy = 0; stalled = 1'b0; held = '0;
    while (n < 64 && guard < 5000) begin
      if (stalled && (!bus.out_valid || bus.out_data != held)) bad_stable++;
      if (bus.in_ready) bad_inrdy++;
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rdy;
      stalled = 1'b0;
      if (bus.out_valid) begin
        if (rdy) begin
          got[n] = int'($signed(bus.out_data));
          n++;
        end else begin
          stalled = 1'b1;
          held = bus.out_data;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.out_ready = 1'b0;
    check_eq({name, " beats"}, n, 64);
    check_eq({name, " stall_stable"}, bad_stable, 0);
    check_eq({name, " in_ready_low"}, bad_inrdy, 0);
    check_eq({name, " end out_valid"}, bus.out_valid, 0);
    check_eq({name, " end in_ready"}, bus.in_ready, 1);
    check_eq({name, " end busy"}, bus.busy, 0);
    for (int k = 0; k < n; k++) check_eq($sformatf("%s coef%0d", name, k), got[k], fexp[k]);
  endtask

  initial begin
    build_rom();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1;
    check_eq("rst in_ready", bus.in_ready, 1);
    check_eq("rst busy", bus.busy, 0);
    check_eq("rst out_valid", bus.out_valid, 0);
    check_eq("rst out_data", bus.out_data, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    fill(16); model();
    load_block(1'b0, 1'b0);
    run_block(1'b0, "all16");
    check_eq("all16 dc", got[0], 128);

    fill(0); xin[0] = 64; model();
    load_block(1'b0, 1'b0);
    run_block(1'b0, "impulse");
    check_eq("impulse f00", got[0], 8);
    check_eq("impulse f01", got[1], 11);

    fill(32767); model();
    load_block(1'b0, 1'b0);
    run_block(1'b0, "maxpos");
    check_eq("maxpos dc", got[0], 32767);

    fill(-32768); model();
    load_block(1'b0, 1'b0);
    run_block(1'b0, "maxneg");
    check_eq("maxneg dc", got[0], -32768);

    fill(-16); model();
    load_block(1'b1, 1'b0);
    run_block(1'b1, "neg16");
    check_eq("neg16 dc", got[0], -128);

    // in_valid stays high through ROW/COL; the following block must be unaffected.
    fill_rand(); model();
    load_block(1'b0, 1'b1);
    run_block(1'b0, "held");
    fill_rand(); model();
    load_block(1'b0, 1'b0);
    run_block(1'b1, "after_held");

    // Reset in the middle of the column pass.
    fill(16);
    load_block(1'b0, 1'b0);
    repeat (700) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst out_valid", bus.out_valid, 0);
    check_eq("midrst busy", bus.busy, 0);
    check_eq("midrst in_ready", bus.in_ready, 1);
    check_eq("midrst out_data", bus.out_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fill(16); model();
    load_block(1'b0, 1'b0);
    run_block(1'b0, "post_rst");
    check_eq("post_rst dc", got[0], 128);

    for (int b = 0; b < 2; b++) begin
      fill_rand(); model();
      load_block(1'b1, 1'b0);
      run_block(1'b1, $sformatf("rand%0d", b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
